// File: rtl/lfsr_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_rr_scheduler_pkg
// Shared definitions for the LFSR round-robin scheduler:
//   - FSM state encoding (WARMUP, SERVE)
//   - default LFSR width, seed and feedback taps (N=4, maximal length, period 15)
//   - small helper for modulo-R pointer increment
// -----------------------------------------------------------------------------
package lfsr_rr_scheduler_pkg;

   localparam logic [0:0] FSM_WARMUP = 1'b0;
   localparam logic [0:0] FSM_SERVE  = 1'b1;

   localparam int unsigned LFSR_N_DEFAULT    = 32'd4;
   localparam logic [3:0]  LFSR_TAPS_DEFAULT = 4'b0011;
   localparam logic [3:0]  LFSR_SEED_DEFAULT = 4'b0001;

   // Increment v, wrapping to zero at m.
   function automatic int unsigned rr_wrap_inc(input int unsigned v, input int unsigned m);
      int unsigned r;
      if ((v + 32'd1) >= m) begin
         r = 32'd0;
      end else begin
         r = v + 32'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/lfsr_rr_scheduler_lfsr_next.sv
// -----------------------------------------------------------------------------
// lfsr_next
// Purely combinational Fibonacci-style LFSR step:
//   feedback   = XOR-reduce(state & TAPS)
//   next_state = {feedback, state[N-1:1]}
// Ports:
//   state      in  N  current LFSR state
//   next_state out N  state after one advance
// -----------------------------------------------------------------------------
module lfsr_next
   import lfsr_rr_scheduler_pkg::*;
#(
   parameter int unsigned  N    = LFSR_N_DEFAULT,
   parameter logic [N-1:0] TAPS = LFSR_TAPS_DEFAULT
) (
   input  logic [N-1:0] state,
   output logic [N-1:0] next_state
);

   logic feedback_s;

   // Feedback bit and shifted next state.
   always_comb begin
      feedback_s = ^(state & TAPS);
      next_state = {feedback_s, state[N-1:1]};
   end

endmodule

// File: rtl/lfsr_rr_scheduler.sv
// -----------------------------------------------------------------------------
// lfsr_rr_scheduler
// Shares one LFSR among R requesters. A round-robin arbiter grants at most one
// requester per cycle and hands it the current LFSR word; the LFSR advances
// exactly once per grant so no two consumers see the same sample. After reset
// or a reseed, the first WARMUP states are discarded before serving.
// Ports:
//   clk        in   1  clock, rising edge
//   reset      in   1  synchronous, active-high reset
//   req        in   R  per-requester level request
//   seed_load  in   1  one-cycle pulse: load seed_val, restart warm-up
//   seed_val   in   N  new seed (zero is replaced by SEED)
//   gnt        out  R  registered one-hot (or zero) grant pulse
//   rnd        out  N  registered random word, valid with rnd_valid
//   rnd_valid  out  1  high in the cycle gnt is non-zero
//   busy       out  1  high while warming up
// -----------------------------------------------------------------------------
module lfsr_rr_scheduler
   import lfsr_rr_scheduler_pkg::*;
#(
   parameter int unsigned  N      = LFSR_N_DEFAULT,
   parameter logic [N-1:0] TAPS   = LFSR_TAPS_DEFAULT,
   parameter logic [N-1:0] SEED   = LFSR_SEED_DEFAULT,
   parameter int unsigned  R      = 32'd3,
   parameter int unsigned  WARMUP = 32'd2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [R-1:0] req,
   input  logic         seed_load,
   input  logic [N-1:0] seed_val,
   output logic [R-1:0] gnt,
   output logic [N-1:0] rnd,
   output logic         rnd_valid,
   output logic         busy
);

   localparam int unsigned PW = $clog2(R);
   localparam int unsigned CW = (WARMUP > 32'd1) ? $clog2(WARMUP) : 32'd1;
   localparam logic [CW-1:0] WARM_LAST =
      (WARMUP > 32'd0) ? CW'(int'(WARMUP) - 32'sd1) : {CW{1'b0}};
   // State entered after reset or reseed: warm-up is skipped entirely when WARMUP is 0.
   localparam logic [0:0] FSM_RESTART = (WARMUP > 32'd0) ? FSM_WARMUP : FSM_SERVE;

   logic [N-1:0]  state_r;
   logic [0:0]    fsm_r;
   logic [CW-1:0] count_r;
   logic [PW-1:0] ptr_r;
   logic [R-1:0]  gnt_r;
   logic [N-1:0]  rnd_r;
   logic          rnd_valid_r;

   logic [N-1:0]  next_state_s;
   logic [N-1:0]  seed_state_s;
   logic          grant_found_s;
   logic [PW-1:0] grant_idx_s;
   logic [R-1:0]  grant_onehot_s;
   logic [PW-1:0] ptr_next_s;

   lfsr_next #(
      .N    (N),
      .TAPS (TAPS)
   ) u_lfsr_next (
      .state      (state_r),
      .next_state (next_state_s)
   );

   // Zero seed would lock the LFSR up, so it is replaced by SEED.
   always_comb begin
      if (seed_val == {N{1'b0}}) begin
         seed_state_s = SEED;
      end else begin
         seed_state_s = seed_val;
      end
   end

   // Round-robin search: first set request at or after the pointer, wrapping modulo R.
   always_comb begin
      int idx;
      idx            = 0;
      grant_found_s  = 1'b0;
      grant_idx_s    = {PW{1'b0}};
      for (int i = 0; i < int'(R); i++) begin
         idx = (int'(ptr_r) + i) % int'(R);
         if (!grant_found_s && req[idx]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = PW'(idx);
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // One-hot grant vector and the pointer value that follows this grant.
   always_comb begin
      if (grant_found_s) begin
         grant_onehot_s = {{(R-1){1'b0}}, 1'b1} << grant_idx_s;
      end else begin
         grant_onehot_s = {R{1'b0}};
      end
      ptr_next_s = PW'(rr_wrap_inc(32'(grant_idx_s), R));
   end

   // Scheduler FSM, LFSR state, pointer and registered outputs.
   // Priority: reset > seed_load > normal WARMUP/SERVE operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= SEED;
         fsm_r       <= FSM_RESTART;
         count_r     <= {CW{1'b0}};
         ptr_r       <= {PW{1'b0}};
         gnt_r       <= {R{1'b0}};
         rnd_r       <= {N{1'b0}};
         rnd_valid_r <= 1'b0;
      end else if (seed_load) begin
         // Overrides any same-cycle grant; pointer and rnd are kept.
         state_r     <= seed_state_s;
         fsm_r       <= FSM_RESTART;
         count_r     <= {CW{1'b0}};
         gnt_r       <= {R{1'b0}};
         rnd_valid_r <= 1'b0;
      end else begin
         case (fsm_r)
            FSM_WARMUP: begin
               // Requests are ignored; each cycle discards one LFSR state.
               state_r     <= next_state_s;
               gnt_r       <= {R{1'b0}};
               rnd_valid_r <= 1'b0;
               if (count_r == WARM_LAST) begin
                  fsm_r   <= FSM_SERVE;
                  count_r <= {CW{1'b0}};
               end else begin
                  count_r <= count_r + CW'(1'b1);
               end
            end
            FSM_SERVE: begin
               if (grant_found_s) begin
                  // The granted requester gets the current word; LFSR advances once.
                  gnt_r       <= grant_onehot_s;
                  rnd_r       <= state_r;
                  rnd_valid_r <= 1'b1;
                  state_r     <= next_state_s;
                  ptr_r       <= ptr_next_s;
               end else begin
                  gnt_r       <= {R{1'b0}};
                  rnd_valid_r <= 1'b0;
               end
            end
            default: begin
               fsm_r       <= FSM_RESTART;
               count_r     <= {CW{1'b0}};
               gnt_r       <= {R{1'b0}};
               rnd_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign gnt       = gnt_r;
   assign rnd       = rnd_r;
   assign rnd_valid = rnd_valid_r;
   assign busy      = (fsm_r == FSM_WARMUP);

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lfsr_rr_scheduler
// Directed bench for lfsr_rr_scheduler. Instance dut uses the defaults
// (N=4, TAPS=0011, SEED=0001, R=3, WARMUP=2); instance dut0 uses WARMUP=0.
// Expected values are hand-computed from the LFSR sequence of TAPS=0011:
//   0001 1000 0100 0010 1001 1100 0110 1011 0101 1010 1101 1110 1111 0111 0011
// -----------------------------------------------------------------------------
module tb_lfsr_rr_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] req, req0;
   logic       seed_load, seed_load0;
   logic [3:0] seed_val, seed_val0;
   logic [2:0] gnt, gnt0;
   logic [3:0] rnd, rnd0;
   logic       rnd_valid, rnd_valid0;
   logic       busy, busy0;

   int checks = 0;
   int errors = 0;

   logic [3:0] seq [15] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b1001,
                            4'b1100, 4'b0110, 4'b1011, 4'b0101, 4'b1010,
                            4'b1101, 4'b1110, 4'b1111, 4'b0111, 4'b0011};
   logic [2:0] rr_gnt [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
   logic [3:0] rr_rnd [4] = '{4'b0100, 4'b0010, 4'b1001, 4'b1100};

   always #5 clk = ~clk;

   lfsr_rr_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .seed_load (seed_load),
      .seed_val  (seed_val),
      .gnt       (gnt),
      .rnd       (rnd),
      .rnd_valid (rnd_valid),
      .busy      (busy)
   );

   lfsr_rr_scheduler #(.WARMUP(0)) dut0 (
      .clk       (clk),
      .reset     (reset),
      .req       (req0),
      .seed_load (seed_load0),
      .seed_val  (seed_val0),
      .gnt       (gnt0),
      .rnd       (rnd0),
      .rnd_valid (rnd_valid0),
      .busy      (busy0)
   );

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; req = 3'b000; seed_load = 1'b0; seed_val = 4'b0000;
      req0 = 3'b000; seed_load0 = 1'b0; seed_val0 = 4'b0000;
      tick();
      check_val("rst_busy", 16'(busy), 16'h1);
      check_val("rst_gnt", 16'(gnt), 16'h0);
      check_val("rst_rnd", 16'(rnd), 16'h0);
      check_val("rst_valid", 16'(rnd_valid), 16'h0);
      check_val("rst_state", 16'(dut.state_r), 16'h1);
      check_val("rst_busy0", 16'(busy0), 16'h0);

      // Warm-up: two busy cycles, 0001 -> 1000 -> 0100.
      reset = 1'b0;
      tick();
      check_val("wu1_state", 16'(dut.state_r), 16'h8);
      check_val("wu1_busy", 16'(busy), 16'h1);
      check_val("wu1_gnt", 16'(gnt), 16'h0);
      tick();
      check_val("wu2_state", 16'(dut.state_r), 16'h4);
      check_val("wu2_busy", 16'(busy), 16'h0);
      check_val("wu2_gnt", 16'(gnt), 16'h0);

      // Single continuous requester: 16 grants cover the full period plus one.
      req = 3'b001;
      for (int n = 0; n < 16; n++) begin
         tick();
         check_val("single_gnt", 16'(gnt), 16'h1);
         check_val("single_rnd", 16'(rnd), 16'(seq[(2 + n) % 15]));
         check_val("single_valid", 16'(rnd_valid), 16'h1);
      end
      req = 3'b000;
      tick();
      check_val("idle_gnt", 16'(gnt), 16'h0);
      check_val("idle_valid", 16'(rnd_valid), 16'h0);
      check_val("idle_rnd_hold", 16'(rnd), 16'h4);
      check_val("idle_state", 16'(dut.state_r), 16'h2);

      // Fresh start, then all three requesting from pointer 0.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      tick();
      req = 3'b111;
      for (int n = 0; n < 4; n++) begin
         tick();
         check_val("rr_gnt", 16'(gnt), 16'(rr_gnt[n]));
         check_val("rr_rnd", 16'(rnd), 16'(rr_rnd[n]));
      end
      // Pointer is now 1: requester 2 first, then wrap to 0.
      req = 3'b101;
      tick();
      check_val("p1_gnt_a", 16'(gnt), 16'h4);
      check_val("p1_rnd_a", 16'(rnd), 16'h6);
      tick();
      check_val("p1_gnt_b", 16'(gnt), 16'h1);
      check_val("p1_rnd_b", 16'(rnd), 16'hB);

      // Zero-seed load in SERVE with a pending request.
      req = 3'b001; seed_load = 1'b1; seed_val = 4'b0000;
      tick();
      seed_load = 1'b0;
      check_val("sl_gnt", 16'(gnt), 16'h0);
      check_val("sl_valid", 16'(rnd_valid), 16'h0);
      check_val("sl_busy", 16'(busy), 16'h1);
      check_val("sl_state", 16'(dut.state_r), 16'h1);
      check_val("sl_rnd_hold", 16'(rnd), 16'hB);
      tick();
      check_val("sl_wu1_busy", 16'(busy), 16'h1);
      check_val("sl_wu1_gnt", 16'(gnt), 16'h0);
      tick();
      check_val("sl_wu2_busy", 16'(busy), 16'h0);
      check_val("sl_wu2_gnt", 16'(gnt), 16'h0);
      tick();
      check_val("sl_first_gnt", 16'(gnt), 16'h1);
      check_val("sl_first_rnd", 16'(rnd), 16'h4);
      tick();
      check_val("sl_second_rnd", 16'(rnd), 16'h2);

      // Reset mid-stream with a request still active.
      reset = 1'b1;
      tick();
      check_val("mid_rst_state", 16'(dut.state_r), 16'h1);
      check_val("mid_rst_gnt", 16'(gnt), 16'h0);
      check_val("mid_rst_rnd", 16'(rnd), 16'h0);
      check_val("mid_rst_valid", 16'(rnd_valid), 16'h0);
      check_val("mid_rst_busy", 16'(busy), 16'h1);
      reset = 1'b0; req = 3'b000;

      // Reseed mid-warm-up restarts the count: 0101 -> 1010 -> 1101.
      tick();
      check_val("mwu_state", 16'(dut.state_r), 16'h8);
      seed_load = 1'b1; seed_val = 4'b0101;
      tick();
      seed_load = 1'b0;
      check_val("mwu_seed_state", 16'(dut.state_r), 16'h5);
      check_val("mwu_seed_busy", 16'(busy), 16'h1);
      tick();
      check_val("mwu_a_busy", 16'(busy), 16'h1);
      check_val("mwu_a_state", 16'(dut.state_r), 16'hA);
      tick();
      check_val("mwu_b_busy", 16'(busy), 16'h0);
      check_val("mwu_b_state", 16'(dut.state_r), 16'hD);
      req = 3'b001;
      tick();
      check_val("mwu_gnt", 16'(gnt), 16'h1);
      check_val("mwu_rnd", 16'(rnd), 16'hD);
      req = 3'b000;

      // Reset wins over a simultaneous seed_load.
      reset = 1'b1; seed_load = 1'b1; seed_val = 4'b1111;
      tick();
      check_val("rst_over_seed", 16'(dut.state_r), 16'h1);
      reset = 1'b0; seed_load = 1'b0;

      // WARMUP=0 instance: serves immediately, no busy.
      req0 = 3'b010;
      tick();
      check_val("w0_busy", 16'(busy0), 16'h0);
      check_val("w0_gnt", 16'(gnt0), 16'h2);
      check_val("w0_rnd", 16'(rnd0), 16'h1);
      req0 = 3'b000; seed_load0 = 1'b1; seed_val0 = 4'b1111;
      tick();
      seed_load0 = 1'b0;
      check_val("w0_sl_busy", 16'(busy0), 16'h0);
      check_val("w0_sl_state", 16'(dut0.state_r), 16'hF);
      check_val("w0_sl_gnt", 16'(gnt0), 16'h0);
      req0 = 3'b001;
      tick();
      check_val("w0_g1_gnt", 16'(gnt0), 16'h1);
      check_val("w0_g1_rnd", 16'(rnd0), 16'hF);
      tick();
      check_val("w0_g2_rnd", 16'(rnd0), 16'h7);
      check_val("w0_g2_valid", 16'(rnd_valid0), 16'h1);
      // Pointer now 1: of requesters 1 and 2, requester 1 wins.
      req0 = 3'b110;
      tick();
      check_val("w0_g3_gnt", 16'(gnt0), 16'h2);
      check_val("w0_g3_rnd", 16'(rnd0), 16'h3);
      req0 = 3'b000;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
